sweep_checker: RTL and testbench

//  Parametrised exhaustive-sweep self-checker: drives every WIDTH-bit input vector 0..2^WIDTH-1

---
 rtl/sweep_checker.sv | 187 ++++++++++++++++++
 tb/tb_sweep_checker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_checker.sv
// sweep_checker: clocked exhaustive-sweep self-checker for a single-output DUT.
// Optional macro STOP_ON_FAIL_EN aborts the sweep on the first mismatch.
module sweep_checker #(
    parameter int unsigned           WIDTH = 4,
    parameter logic [(2**WIDTH)-1:0] TRUTH = 16'h0DD0,
    parameter int unsigned           LAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] stim,
    input  logic             dut_f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_count,
    output logic             first_fail_valid,
    output logic [WIDTH-1:0] first_fail_vec
);

    localparam logic [WIDTH-1:0] LAST_VEC   = '1;
    localparam logic [2:0]       DRAIN_INIT = (LAT == 0) ? 3'd0 : 3'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] stim_q, stim_d;
    logic [WIDTH:0]   err_q, err_d;
    logic             ffv_q, ffv_d;
    logic [WIDTH-1:0] ffvec_q, ffvec_d;
    logic             pass_q, pass_d;
    logic [2:0]       drain_q, drain_d;

    logic             accept;
    logic             issue;
    logic             cmp_valid;
    logic [WIDTH-1:0] cmp_vec;
    logic             mismatch;
    logic             stop;

    assign accept = (state_q == S_IDLE) && start;
    assign issue  = (state_q == S_SWEEP);

    generate
        if (LAT == 0) begin : g_direct
            assign cmp_valid = issue;
            assign cmp_vec   = stim_q;
        end else begin : g_delay
            // Each stage carries {valid, vector}; stage LAT-1 lines up with dut_f.
            logic [LAT-1:0][WIDTH:0] pipe_q;
            logic [LAT:0][WIDTH:0]   pipe_ext;

            assign pipe_ext = {pipe_q, {issue, stim_q}};

            always_ff @(posedge clk) begin
                if (rst || stop) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= pipe_ext[LAT-1:0];
                end
            end

            assign cmp_valid = pipe_q[LAT-1][WIDTH];
            assign cmp_vec   = pipe_q[LAT-1][WIDTH-1:0];
        end
    endgenerate

    assign mismatch = cmp_valid && (dut_f != TRUTH[cmp_vec]);

`ifdef STOP_ON_FAIL_EN
    assign stop = mismatch;
`else
    assign stop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_SWEEP;
            end
            S_SWEEP: begin
                if (stop) begin
                    state_d = S_DONE;
                end else if (stim_q == LAST_VEC) begin
                    state_d = (LAT == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (stop || (drain_q == '0)) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_SWEEP, S_DRAIN: busy = 1'b1;
            S_DONE:           done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        stim_d  = '0;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;
        pass_d  = pass_q;
        drain_d = drain_q;

        if (accept) begin
            err_d   = '0;
            ffv_d   = 1'b0;
            ffvec_d = '0;
            pass_d  = 1'b0;
        end

        if ((state_q == S_SWEEP) && (state_d == S_SWEEP)) begin
            stim_d = stim_q + 1'b1;
        end

        if (mismatch) begin
            err_d = err_q + 1'b1;
            if (!ffv_q) begin
                ffv_d   = 1'b1;
                ffvec_d = cmp_vec;
            end
        end

        if ((state_q == S_SWEEP) && (state_d == S_DRAIN)) begin
            drain_d = DRAIN_INIT;
        end else if (state_q == S_DRAIN) begin
            drain_d = drain_q - 1'b1;
        end

        // Verdict taken on the edge into DONE so the final compare is included.
        if (state_d == S_DONE) begin
            pass_d = (err_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stim_q  <= '0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
            pass_q  <= 1'b0;
            drain_q <= '0;
        end else begin
            stim_q  <= stim_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
            pass_q  <= pass_d;
            drain_q <= drain_d;
        end
    end

    assign stim             = stim_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_sweep_checker.sv
// Scoreboard bench for sweep_checker: one LAT=0 and one LAT=3 instance, each
// fed by a bench-side DUT model whose behaviour is selected per sweep.
module tb_sweep_checker;

    localparam int W = 4;

    typedef struct {
        int cyc;
        int err;
        int ffv;
        int ffvec;
        int pass;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start_s  [2];
    logic [W-1:0] stim_s   [2];
    logic         busy_s   [2];
    logic         done_s   [2];
    logic         pass_s   [2];
    logic [W:0]   err_s    [2];
    logic         ffv_s    [2];
    logic [W-1:0] ffvec_s  [2];
    logic         dut_f0;
    logic         dut_f1;
    int           mode_s   [2];
    int           done_cnt [2];

    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   stimq0[$];
    int   stimq1[$];
    res_t resq0[$];
    res_t resq1[$];

    always @(posedge clk) cyc <= cyc + 1;

    sweep_checker #(.WIDTH(4), .TRUTH(16'h0DD0), .LAT(0)) u_lat0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .stim(stim_s[0]), .dut_f(dut_f0),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_count(err_s[0]),
        .first_fail_valid(ffv_s[0]), .first_fail_vec(ffvec_s[0])
    );

    sweep_checker #(.WIDTH(4), .TRUTH(16'h0DD0), .LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .start(start_s[1]), .stim(stim_s[1]), .dut_f(dut_f1),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_count(err_s[1]),
        .first_fail_valid(ffv_s[1]), .first_fail_vec(ffvec_s[1])
    );

    // F = (A xor B) and (C or not D), vector = {A,B,C,D}
    function automatic logic gold(input int v);
        logic a, b, c, d;
        a = v[3]; b = v[2]; c = v[1]; d = v[0];
        return (a ^ b) & (c | ~d);
    endfunction

    // mode 0: correct, 1: stuck-at-0 (LAT0) / one stage short (LAT3), 2: inverted
    always_comb begin
        case (mode_s[0])
            1:       dut_f0 = 1'b0;
            2:       dut_f0 = ~gold(int'(stim_s[0]));
            default: dut_f0 = gold(int'(stim_s[0]));
        endcase
    end

    logic p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;
    always @(posedge clk) begin
        p1 <= gold(int'(stim_s[1]));
        p2 <= p1;
        p3 <= p2;
    end

    always_comb begin
        case (mode_s[1])
            1:       dut_f1 = p2;
            2:       dut_f1 = ~p3;
            default: dut_f1 = p3;
        endcase
    end

    function automatic logic exp_f(input int s, input int mode, input int v);
        case (mode)
            1:       return (s == 0) ? 1'b0 : gold((v + 1) % 16);
            2:       return ~gold(v);
            default: return gold(v);
        endcase
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset(input int s);
        check($sformatf("u%0d rst stim", s),  int'(stim_s[s]),  0);
        check($sformatf("u%0d rst busy", s),  int'(busy_s[s]),  0);
        check($sformatf("u%0d rst done", s),  int'(done_s[s]),  0);
        check($sformatf("u%0d rst pass", s),  int'(pass_s[s]),  0);
        check($sformatf("u%0d rst err", s),   int'(err_s[s]),   0);
        check($sformatf("u%0d rst ffv", s),   int'(ffv_s[s]),   0);
        check($sformatf("u%0d rst ffvec", s), int'(ffvec_s[s]), 0);
    endtask

    task automatic mon(input int s);
        res_t r;
        int   n;
        int   e;
        if (busy_s[s]) begin
            n = (s == 0) ? stimq0.size() : stimq1.size();
            if (n == 0) begin
                check($sformatf("u%0d busy_unexp", s), int'(busy_s[s]), 0);
            end else begin
                if (s == 0) e = stimq0.pop_front();
                else        e = stimq1.pop_front();
                check($sformatf("u%0d stim", s), int'(stim_s[s]), e);
            end
        end
        if (done_s[s]) begin
            done_cnt[s]++;
            n = (s == 0) ? resq0.size() : resq1.size();
            if (n == 0) begin
                check($sformatf("u%0d done_unexp", s), int'(done_s[s]), 0);
            end else begin
                if (s == 0) r = resq0.pop_front();
                else        r = resq1.pop_front();
                check($sformatf("u%0d done_cyc", s),  cyc,               r.cyc);
                check($sformatf("u%0d err", s),       int'(err_s[s]),   r.err);
                check($sformatf("u%0d ffv", s),       int'(ffv_s[s]),   r.ffv);
                check($sformatf("u%0d ffvec", s),     int'(ffvec_s[s]), r.ffvec);
                check($sformatf("u%0d pass", s),      int'(pass_s[s]),  r.pass);
                check($sformatf("u%0d busy@done", s), int'(busy_s[s]),  0);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Drives start for 'hold' cycles and pushes the expected stim stream and
    // result record of every sweep that start is expected to trigger.
    task automatic launch(input int s, input int mode, input int hold);
        int   nerr, first, lat, nb, per, t0, dc0, edone;
        res_t r;
        nerr  = 0;
        first = -1;
        lat   = (s == 0) ? 0 : 3;
        for (int v = 0; v < 16; v++) begin
            if (exp_f(s, mode, v) != gold(v)) begin
                nerr++;
                if (first < 0) first = v;
            end
        end
        nb = 16 + lat;
`ifdef STOP_ON_FAIL_EN
        if (nerr > 0) begin
            nerr = 1;
            nb   = first + 1 + lat;
        end
`endif
        per = nb + 2;
        @(posedge clk);
        #1;
        mode_s[s]  = mode;
        start_s[s] = 1'b1;
        @(negedge clk);
        t0    = cyc;
        edone = 0;
        for (int k = 0; k * per < hold; k++) begin
            for (int i = 1; i <= nb; i++) begin
                if (s == 0) stimq0.push_back((i - 1 < 16) ? i - 1 : 0);
                else        stimq1.push_back((i - 1 < 16) ? i - 1 : 0);
            end
            r.cyc   = t0 + k * per + nb + 1;
            r.err   = nerr;
            r.ffv   = (nerr > 0) ? 1 : 0;
            r.ffvec = (first < 0) ? 0 : first;
            r.pass  = (nerr == 0) ? 1 : 0;
            if (s == 0) resq0.push_back(r);
            else        resq1.push_back(r);
            if (k * per + nb + 1 < hold) edone++;
        end
        dc0 = done_cnt[s];
        repeat (hold - 1) @(negedge clk);
        @(posedge clk);
        #1;
        start_s[s] = 1'b0;
        if (hold > 1) check($sformatf("u%0d held_dones", s), done_cnt[s] - dc0, edone);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && (resq0.size() + resq1.size()) > 0; i++) @(negedge clk);
        if ((resq0.size() + resq1.size()) > 0) begin
            check("timeout_pending", resq0.size() + resq1.size(), 0);
            resq0.delete();
            resq1.delete();
            stimq0.delete();
            stimq1.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        start_s[0]  = 1'b0;
        start_s[1]  = 1'b0;
        mode_s[0]   = 0;
        mode_s[1]   = 0;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset(0);
        check_reset(1);

        launch(0, 0, 1); wait_drain(60);
        launch(0, 1, 1); wait_drain(60);
        launch(1, 0, 1); wait_drain(60);
        launch(1, 1, 1); wait_drain(60);

        // reset in the cycle vector 7 is on stim
        launch(0, 0, 1);
        for (int i = 0; i < 40 && !(busy_s[0] && stim_s[0] == 4'd7); i++) @(negedge clk);
        check("reach_vec7", int'(stim_s[0]), 7);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        stimq0.delete();
        resq0.delete();
        @(negedge clk);
        check_reset(0);
        repeat (25) @(negedge clk);
        launch(0, 0, 1); wait_drain(60);

        // leave stale failures, then hold start for 30 cycles
        launch(0, 1, 1);  wait_drain(60);
        launch(0, 0, 30); wait_drain(80);

        launch(0, 2, 1); wait_drain(60);

        check("leftover_res", resq0.size() + resq1.size(), 0);
        check("leftover_stim", stimq0.size() + stimq1.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=%0t expected=finish", $time);
        $fatal(1, "global timeout");
    end

endmodule
